lif_spike_packer: RTL and testbench

- Sits directly downstream of the 4-timestep LIF group.
- Takes one TIME_STEPS-bit spike vector per neuron per valid cycle and packs GROUPS_PER_WORD vectors into one OUT_WIDTH-bit word.
- Buffers packed words in a small FIFO and presents them on a valid/ready stream to the spike write-back / on-chip buffer stage.
- Handles row boundaries: a partial word at the end of a row is flushed zero-padded and tagged with last.

---
 rtl/lif_spike_packer_pkg.sv | 17 +
 rtl/lif_spike_packer_fifo.sv | 61 ++++++
 rtl/lif_spike_packer.sv | 120 ++++++++++++
 tb/tb_lif_spike_packer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lif_spike_packer_pkg.sv
// Shared constants and word type for the LIF spike packer.
package lif_spike_packer_pkg;

    localparam int TIME_STEPS = 4;

    localparam int GROUPS_PER_WORD_DEF = 16;
    localparam int OUT_WIDTH_DEF       = TIME_STEPS * GROUPS_PER_WORD_DEF;
    localparam int FIFO_DEPTH_DEF      = 4;
    localparam int ROW_LEN_W_DEF       = 12;
    localparam int CNT_W               = 16;

    typedef struct packed {
        logic                     last;
        logic [OUT_WIDTH_DEF-1:0] data;
    } pack_word_t;

endpackage

// File: rtl/lif_spike_packer_fifo.sv
// First-word-fall-through FIFO with a registered head; a push into a full
// FIFO is accepted only when a pop frees a slot in the same cycle.
module spike_pack_fifo #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 4
) (
    input  logic             s_clk,
    input  logic             s_rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             head_valid,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr, rd_nxt;
    logic [AW:0]      count, count_nxt;
    logic             do_push, do_pop;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        full      = (count == (AW+1)'(DEPTH));
        do_pop    = pop && head_valid;
        do_push   = push && (!full || do_pop);
        rd_nxt    = do_pop ? rd_ptr + AW'(1) : rd_ptr;
        count_nxt = count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    // NOTE: storage has no reset; validity is tracked by count/head_valid alone.
    always_ff @(posedge s_clk) begin
        if (do_push)
            mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge s_clk) begin
        if (s_rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            head_valid <= 1'b0;
            head_data  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            rd_ptr <= rd_nxt;
            count  <= count_nxt;
            if (count_nxt == '0) begin
                head_valid <= 1'b0;
            end else begin
                head_valid <= 1'b1;
                // Reload the head only when it is consumed or was empty.
                if (do_pop || !head_valid)
                    head_data <= (do_push && wr_ptr == rd_nxt) ? push_data : mem[rd_nxt];
            end
        end
    end

endmodule

// File: rtl/lif_spike_packer.sv
// Packs per-neuron LIF spike vectors into wide words, closing on full word or
// row end. Define SPIKE_PACK_CNT_EN to add per-timestep spike counters.
module lif_spike_packer
    import lif_spike_packer_pkg::*;
#(
    parameter int GROUPS_PER_WORD = GROUPS_PER_WORD_DEF,
    parameter int OUT_WIDTH       = TIME_STEPS * GROUPS_PER_WORD,
    parameter int FIFO_DEPTH      = FIFO_DEPTH_DEF,
    parameter int ROW_LEN_W       = ROW_LEN_W_DEF
) (
    input  logic                  s_clk,
    input  logic                  s_rst,
    input  logic [ROW_LEN_W-1:0]  i_row_len,
    input  logic                  i_spikes_valid,
    input  logic [TIME_STEPS-1:0] i_spikes,
    output logic                  o_word_valid,
    output logic [OUT_WIDTH-1:0]  o_word_data,
    output logic                  o_word_last,
    input  logic                  i_word_ready,
    output logic                  o_overflow,
    output logic                  o_busy
`ifdef SPIKE_PACK_CNT_EN
    ,
    input  logic                        i_cnt_clr,
    output logic [TIME_STEPS*CNT_W-1:0] o_spike_cnt
`endif
);
    localparam int GW = (GROUPS_PER_WORD > 1) ? $clog2(GROUPS_PER_WORD) : 1;

    logic [OUT_WIDTH-1:0] pack_q, word_nxt, stage_data;
    logic [GW-1:0]        grp_cnt;
    logic [ROW_LEN_W-1:0] row_cnt, row_cnt_inc, row_len_q, row_len_eff;
    logic                 row_open, row_end, grp_end, word_close;
    logic                 stage_vld, stage_last;
    logic                 fifo_full, fifo_pop;

    always_comb begin
        row_len_eff = row_open ? row_len_q : i_row_len;
        row_cnt_inc = row_cnt + ROW_LEN_W'(1);
        // A zero row length wraps the counter back to 0, i.e. 2^ROW_LEN_W neurons.
        row_end     = (row_cnt_inc == row_len_eff);
        grp_end     = (grp_cnt == GW'(GROUPS_PER_WORD - 1));
        word_close  = row_end || grp_end;
        word_nxt    = pack_q | (OUT_WIDTH'(i_spikes) << (int'(grp_cnt) * TIME_STEPS));
        fifo_pop    = o_word_valid && i_word_ready;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge s_clk) begin
        if (s_rst) begin
            pack_q     <= '0;
            grp_cnt    <= '0;
            row_cnt    <= '0;
            row_len_q  <= '0;
            row_open   <= 1'b0;
            stage_vld  <= 1'b0;
            stage_data <= '0;
            stage_last <= 1'b0;
            o_overflow <= 1'b0;
        end else begin
            stage_vld <= 1'b0;
            if (i_spikes_valid) begin
                if (!row_open)
                    row_len_q <= i_row_len;
                stage_vld  <= word_close;
                stage_data <= word_nxt;
                stage_last <= row_end;
                if (word_close) begin
                    pack_q  <= '0;
                    grp_cnt <= '0;
                end else begin
                    pack_q  <= word_nxt;
                    grp_cnt <= grp_cnt + GW'(1);
                end
                row_cnt  <= row_end ? '0 : row_cnt_inc;
                row_open <= !row_end;
            end
            if (stage_vld && fifo_full && !fifo_pop)
                o_overflow <= 1'b1;
        end
    end

    spike_pack_fifo #(
        .WIDTH (OUT_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .s_clk      (s_clk),
        .s_rst      (s_rst),
        .push       (stage_vld),
        .push_data  ({stage_last, stage_data}),
        .pop        (fifo_pop),
        .head_data  ({o_word_last, o_word_data}),
        .head_valid (o_word_valid),
        .full       (fifo_full)
    );

    assign o_busy = (grp_cnt != '0) || stage_vld || o_word_valid;

`ifdef SPIKE_PACK_CNT_EN
    logic [CNT_W-1:0] cnt_q [TIME_STEPS];

    // Clear wins over increment; counters saturate at all-ones.
    always_ff @(posedge s_clk) begin
        for (int t = 0; t < TIME_STEPS; t++) begin
            if (s_rst || i_cnt_clr)
                cnt_q[t] <= '0;
            else if (i_spikes_valid && i_spikes[t] && cnt_q[t] != '1)
                cnt_q[t] <= cnt_q[t] + CNT_W'(1);
        end
    end

    always_comb begin
        o_spike_cnt = '0;
        for (int t = 0; t < TIME_STEPS; t++)
            o_spike_cnt[t*CNT_W +: CNT_W] = cnt_q[t];
    end
`endif

endmodule

// File: tb/tb_lif_spike_packer.sv
// Self-checking bench for lif_spike_packer: table vectors, hand sequences and
// a word scoreboard fed by a small packing model.
module tb_lif_spike_packer;
    import lif_spike_packer_pkg::*;

    logic        s_clk = 1'b0;
    logic        s_rst;
    logic [11:0] i_row_len;
    logic        i_spikes_valid;
    logic [3:0]  i_spikes;
    logic        o_word_valid;
    logic [63:0] o_word_data;
    logic        o_word_last;
    logic        i_word_ready;
    logic        o_overflow;
    logic        o_busy;
`ifdef SPIKE_PACK_CNT_EN
    logic        i_cnt_clr;
    logic [63:0] o_spike_cnt;
`endif

    lif_spike_packer dut (
        .s_clk          (s_clk),
        .s_rst          (s_rst),
        .i_row_len      (i_row_len),
        .i_spikes_valid (i_spikes_valid),
        .i_spikes       (i_spikes),
        .o_word_valid   (o_word_valid),
        .o_word_data    (o_word_data),
        .o_word_last    (o_word_last),
        .i_word_ready   (i_word_ready),
        .o_overflow     (o_overflow),
        .o_busy         (o_busy)
`ifdef SPIKE_PACK_CNT_EN
        ,
        .i_cnt_clr      (i_cnt_clr),
        .o_spike_cnt    (o_spike_cnt)
`endif
    );

    always #5 s_clk = ~s_clk;

    int checks = 0;
    int errors = 0;
    pack_word_t exp_q[$];

    // Reference packing model.
    int          m_grp = 0;
    int          m_cnt = 0;
    int          m_len = 0;
    logic [63:0] m_word = '0;

    typedef struct {
        logic [11:0] row_len;
        logic [3:0]  spk;
        logic        has_out;
        logic [63:0] data;
        logic        last;
    } vec_t;

    vec_t tbl[9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge s_clk);
        #1;
    endtask

    task automatic push_exp(input logic last, input logic [63:0] data);
        pack_word_t w;
        w.last = last;
        w.data = data;
        exp_q.push_back(w);
    endtask

    task automatic model_step(input logic [3:0] spk);
        pack_word_t w;
        if (m_cnt == 0)
            m_len = (i_row_len == 12'd0) ? 4096 : int'(i_row_len);
        m_word = m_word | (64'(spk) << (m_grp * 4));
        m_grp++;
        m_cnt++;
        if (m_cnt == m_len || m_grp == 16) begin
            w.last = (m_cnt == m_len);
            w.data = m_word;
            exp_q.push_back(w);
            m_word = '0;
            m_grp  = 0;
            if (m_cnt == m_len)
                m_cnt = 0;
        end
    endtask

    task automatic send(input logic [3:0] spk, input logic use_model);
        i_spikes_valid = 1'b1;
        i_spikes       = spk;
        if (use_model)
            model_step(spk);
        tick();
        i_spikes_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check("drain_remaining", 64'(exp_q.size()), 64'd0);
        tick();
        tick();
        check("no_extra_word", o_word_valid, 1'b0);
    endtask

    // Scoreboard: compare every transfer against the head of the queue.
    always @(negedge s_clk) begin
        if (!s_rst && o_word_valid && i_word_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word actual=%h required=none", o_word_data);
            end else begin
                pack_word_t e;
                e = exp_q.pop_front();
                check("word_data", o_word_data, e.data);
                check("word_last", o_word_last, e.last);
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        s_rst          = 1'b1;
        i_row_len      = 12'd16;
        i_spikes_valid = 1'b0;
        i_spikes       = 4'h0;
        i_word_ready   = 1'b0;
`ifdef SPIKE_PACK_CNT_EN
        i_cnt_clr      = 1'b0;
`endif
        tbl[0] = '{12'd1, 4'hA, 1'b1, 64'hA,   1'b1};
        tbl[1] = '{12'd1, 4'h5, 1'b1, 64'h5,   1'b1};
        tbl[2] = '{12'd1, 4'h3, 1'b1, 64'h3,   1'b1};
        tbl[3] = '{12'd1, 4'h0, 1'b1, 64'h0,   1'b1};
        tbl[4] = '{12'd2, 4'h1, 1'b0, 64'h0,   1'b0};
        tbl[5] = '{12'd7, 4'h2, 1'b1, 64'h21,  1'b1};
        tbl[6] = '{12'd3, 4'hC, 1'b0, 64'h0,   1'b0};
        tbl[7] = '{12'd3, 4'h0, 1'b0, 64'h0,   1'b0};
        tbl[8] = '{12'd3, 4'h9, 1'b1, 64'h90C, 1'b1};

        repeat (3) tick();
        check("rst_valid", o_word_valid, 1'b0);
        check("rst_data", o_word_data, 64'h0);
        check("rst_last", o_word_last, 1'b0);
        check("rst_overflow", o_overflow, 1'b0);
        check("rst_busy", o_busy, 1'b0);
        s_rst = 1'b0;
        i_word_ready = 1'b1;

        // One full row of 16 counting vectors; check two-cycle latency.
        i_row_len = 12'd16;
        push_exp(1'b1, 64'h0FED_CBA9_8765_4321);
        for (int k = 0; k < 16; k++)
            send(4'((k + 1) & 15), 1'b0);
        check("lat_edge1_valid", o_word_valid, 1'b0);
        tick();
        check("lat_edge2_valid", o_word_valid, 1'b1);
        wait_drain(20);

        // Row of 20: full word then zero-padded tail; mid-row row_len change ignored.
        i_row_len = 12'd20;
        push_exp(1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
        push_exp(1'b1, 64'h0000_0000_0000_FFFF);
        for (int k = 0; k < 20; k++) begin
            send(4'hF, 1'b0);
            i_row_len = 12'd3;
        end
        wait_drain(20);

        // Table: short rows, including back-to-back single-vector rows.
        for (int i = 0; i < 9; i++) begin
            i_row_len = tbl[i].row_len;
            if (tbl[i].has_out)
                push_exp(tbl[i].last, tbl[i].data);
            send(tbl[i].spk, 1'b0);
        end
        wait_drain(20);

        // Backpressure: four words fill the FIFO, the fifth is dropped.
        i_word_ready = 1'b0;
        i_row_len    = 12'd16;
        for (int k = 0; k < 64; k++)
            send(4'($urandom_range(0, 15)), 1'b1);
        repeat (3) tick();
        check("ovf_before_drop", o_overflow, 1'b0);
        check("full_valid", o_word_valid, 1'b1);
        check("hold_data_a", o_word_data, exp_q[0].data);
        for (int k = 0; k < 16; k++)
            send(4'($urandom_range(0, 15)), 1'b1);
        repeat (3) tick();
        check("ovf_after_drop", o_overflow, 1'b1);
        check("hold_data_b", o_word_data, exp_q[0].data);
        check("hold_last", o_word_last, 1'b1);
        check("queued_words", 64'(exp_q.size()), 64'd5);
        exp_q.delete(4);
        i_word_ready = 1'b1;
        wait_drain(20);
        check("ovf_sticky", o_overflow, 1'b1);

        // Reset mid-row discards the partial word.
        i_row_len = 12'd16;
        for (int k = 0; k < 7; k++)
            send(4'h7, 1'b1);
        check("busy_partial", o_busy, 1'b1);
        s_rst = 1'b1;
        exp_q.delete();
        m_grp  = 0;
        m_cnt  = 0;
        m_word = '0;
        tick();
        tick();
        check("rst2_valid", o_word_valid, 1'b0);
        check("rst2_data", o_word_data, 64'h0);
        check("rst2_last", o_word_last, 1'b0);
        check("rst2_overflow", o_overflow, 1'b0);
        check("rst2_busy", o_busy, 1'b0);
        s_rst = 1'b0;
        for (int k = 0; k < 16; k++)
            send(4'($urandom_range(0, 15)), 1'b1);
        check("post_rst_words", 64'(exp_q.size()), 64'd1);
        wait_drain(20);

        // row_len = 0 means 4096 neurons, with random downstream stalls.
        i_row_len = 12'd0;
        for (int k = 0; k < 4096; k++) begin
            i_word_ready = 1'($urandom_range(0, 1));
            send(4'($urandom_range(0, 15)), 1'b1);
        end
        i_word_ready = 1'b1;
        wait_drain(40);
        check("wrap_overflow", o_overflow, 1'b0);
        check("idle_busy", o_busy, 1'b0);

`ifdef SPIKE_PACK_CNT_EN
        i_cnt_clr = 1'b1;
        tick();
        i_cnt_clr = 1'b0;
        check("cnt_pre_clr", o_spike_cnt, 64'h0);
        i_row_len = 12'd10;
        for (int k = 0; k < 10; k++)
            send(4'b0101, 1'b1);
        check("cnt_value", o_spike_cnt, {16'd0, 16'd10, 16'd0, 16'd10});
        i_cnt_clr = 1'b1;
        tick();
        i_cnt_clr = 1'b0;
        check("cnt_clr", o_spike_cnt, 64'h0);
        wait_drain(20);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
